key_extract_engine: RTL
=======================

# key_extract_engine

Per-stage key extractor that feeds the lookup engine of the same stage. It takes the incoming PHV and selects two 48-bit, two 32-bit and two 16-bit containers according to a per-VLAN extraction entry. It also evaluates one conditional comparison and emits the packed lookup key alongside the unmodified PHV. The extraction table is written in-band from the AXI-Stream control path, which is forwarded to the downstream lookup engine.

## Interface
- C_S_AXIS_DATA_WIDTH, 512, control data width
- C_S_AXIS_TUSER_WIDTH, 128, control tuser width
- STAGE_ID, 0, stage number matched in control writes (3 bits used)
- PHV_LEN, 48\*8+32\*8+16\*8+256, PHV width; 48b containers at the MSBs, then 32b, then 16b, then 256b metadata at the LSBs; container 0 of each class is the highest
- KEY_LEN, 48\*2+32\*2+16\*2+5, key width
- KEY_EXT_ID, 1, resource id matched in control writes (5 bits)
- VLAN_OFF, 129, bit offset in the PHV of the 4-bit table index (VLAN id LSBs)
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- phv_in  in  PHV_LEN  packet header vector
- phv_valid_in  in  1  phv_in valid
- ready_out  out  1  upstream may present a PHV
- phv_out  out  PHV_LEN  unmodified PHV
- phv_valid_out  out  1  phv_out valid
- key_out  out  KEY_LEN  packed key
- key_valid_out  out  1  key_out valid (always equal to phv_valid_out)
- ready_in  in  1  downstream lookup engine ready
- c_s_axis_{tdata,tuser,tkeep,tvalid,tlast}  in  control stream
- c_m_axis_{tdata,tuser,tkeep,tvalid,tlast}  out  control stream to the lookup engine

## Operation
- **Table:** 16 entries × 36 bits, implemented in flops, indexed by phv_in[VLAN_OFF+3:VLAN_OFF].
- **Entry layout, MSB→LSB:**
  - sel48_a[3], sel48_b[3], sel32_a[3], sel32_b[3], sel16_a[3], sel16_b[3]
  - cmp_op[2]
  - opA[8], opB[8]
- **Comparator operands:**
  - Bit7 = 1: 7-bit immediate, zero-extended to 16 bits.
  - Bit7 = 0: bits[2:0] select a 16-bit container.
- **cmp_op:**
  - 00 → cond = 1
  - 01 → A > B
  - 10 → A ≥ B
  - 11 → A == B
  - All comparisons are unsigned, 16-bit.
- **key_out layout, MSB→LSB:** c48[sel48_a], c48[sel48_b], c32[sel32_a], c32[sel32_b], c16[sel16_a], c16[sel16_b], {cond, 4'b0000}.
- **Control write:** single beat with tvalid & tlast, where tdata[7:5] == STAGE_ID and tdata[4:0] == KEY_EXT_ID.
  - Index comes from tdata[11:8]; the entry comes from tdata[51:16].
  - Other fields and beats are ignored for write purposes.
  - Multi-beat packets never write.
- **Control forwarding:** every beat, matching or not, is forwarded on c_m_axis through one register stage. The forwarded beat is identical to the input beat.
- **Data pipeline, 2 stages:**
  - S1 registers the PHV and the table entry read.
  - S2 registers phv_out, key_out and the valid signals.
- **Flow control:**
  - ready_out = ready_in.
  - The pipeline advances only when ready_in = 1.
  - While ready_in = 0, S1/S2 contents and outputs hold, and a PHV presented is not accepted.
  - Accept condition: phv_valid_in & ready_out.

## Timing
- Latency: 2 accepted-clock cycles from accept to phv_valid_out, when ready_in stays high.
- Throughput: 1 PHV per cycle.
- Reset (synchronous, rst_n = 0): all outputs are 0, including ready_out = 0, the c_m_axis signals and the valid signals.
  - All table entries are 0 (selectors 0, cmp_op 00 → cond = 1).
  - Pipeline valid bits are cleared.
- Reset mid-flight: in-flight PHVs are dropped; the table is cleared.
- Write and read of the same index in the same cycle: the read returns the old entry. The new entry is visible from the next cycle.
- Write takes effect one cycle after the control beat is accepted; there is no backpressure on the control path.
- phv_valid_in = 0 while ready_in = 1: a bubble propagates; the outputs' valid = 0 and data is don't-care (held).

## Structure
- Shared package: the PHV container offsets and widths, the key field offsets, the control header bit positions, the cmp_op encodings and the entry field offsets. These are shared with the lookup engine and the ALU stages.
- Sub-module key_ext_cfg_table: the 16-entry table, the control decode/write, and the one-register control forwarding. It has a registered read port gated by the advance enable.

## Test plan
- **Reset defaults:** after reset, send a PHV whose 48b containers are 0..7 = 48'h100+i, with no config write → key 48b fields both 48'h100, low 5 bits = 5'b10000, valid 2 cycles later.
- **Configured extraction:** write index 3 with sel48_a=2, sel48_b=5, sel32_a=7, sel32_b=0, sel16_a=1, sel16_b=6, cmp_op=01, opA=container 1 (value 16'h0050), opB=immediate 0x20. Send a PHV with VLAN LSBs = 3 → key holds those containers and cond = 1. Change 16b container 1 to 16'h0010 → cond = 0.
- **Backpressure:** send 4 back-to-back PHVs and drop ready_in for 3 cycles after the 2nd output → outputs hold stable, ready_out = 0, no loss or duplication, order preserved.
- **Write/read collision:** write index 5 in the same cycle a PHV with index 5 is accepted → that PHV uses the old entry and the next PHV uses the new entry.
- **Control filtering:** a beat with STAGE_ID+1, and a 2-beat packet with matching ids → no table change. All beats appear on c_m_axis 1 cycle later, bit-identical.
- **Reset mid-stream:** assert rst_n = 0 with 2 PHVs in flight → the valid signals are 0 on the next cycle and the table has returned to defaults.

Source files
------------

// File: rtl/key_extract_engine_pkg.sv
// Shared definitions for the key extractor, lookup engine and ALU stages:
// PHV container geometry, key layout, control header fields, compare ops
// and the extraction entry format.
package key_extract_engine_pkg;

  // PHV container geometry (container 0 of each class sits highest)
  localparam int C48_W    = 48;
  localparam int C32_W    = 32;
  localparam int C16_W    = 16;
  localparam int NUM_CONT = 8;
  localparam int META_W   = 256;
  localparam int C48_SPAN = C48_W * NUM_CONT;
  localparam int C32_SPAN = C32_W * NUM_CONT;
  localparam int C16_SPAN = C16_W * NUM_CONT;

  // Key: two of each container class plus a 5-bit {cond, 4'b0} tail
  localparam int KEY_TAIL_W = 5;
  localparam int KEY_W      = 2 * C48_W + 2 * C32_W + 2 * C16_W + KEY_TAIL_W;

  // Extraction table geometry
  localparam int TBL_DEPTH = 16;
  localparam int TBL_IDX_W = 4;

  // Control write header fields within tdata
  localparam int CTL_ID_LSB    = 0;
  localparam int CTL_ID_W      = 5;
  localparam int CTL_STAGE_LSB = 5;
  localparam int CTL_STAGE_W   = 3;
  localparam int CTL_IDX_LSB   = 8;
  localparam int CTL_ENTRY_LSB = 16;

  // Comparator operand: bit 7 set means 7-bit immediate, else container select
  localparam int OPERAND_IMM_BIT = 7;

  typedef enum logic [1:0] {
    CMP_TRUE = 2'b00,
    CMP_GT   = 2'b01,
    CMP_GE   = 2'b10,
    CMP_EQ   = 2'b11
  } cmp_op_e;

  // Entry layout, MSB first
  typedef struct packed {
    logic [2:0] sel48_a;
    logic [2:0] sel48_b;
    logic [2:0] sel32_a;
    logic [2:0] sel32_b;
    logic [2:0] sel16_a;
    logic [2:0] sel16_b;
    logic [1:0] cmp_op;
    logic [7:0] op_a;
    logic [7:0] op_b;
  } key_entry_t;

  localparam int ENTRY_W = $bits(key_entry_t);

  // Unsigned 16-bit condition evaluation
  function automatic logic cmp_eval(input logic [1:0] op,
                                    input logic [C16_W-1:0] a,
                                    input logic [C16_W-1:0] b);
    logic r;
    r = 1'b1;
    case (op)
      CMP_GT:  r = (a > b);
      CMP_GE:  r = (a >= b);
      CMP_EQ:  r = (a == b);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_extract_engine_cfg_table.sv
// Extraction table: decodes single-beat control writes addressed to this
// stage/resource, stores 16 entries in flops, exposes a registered read port
// gated by the pipeline advance, and forwards every control beat one cycle
// later unchanged.
module key_ext_cfg_table
  import key_extract_engine_pkg::*;
#(
  parameter int                     DATA_W     = 512,
  parameter int                     TUSER_W    = 128,
  parameter logic [CTL_STAGE_W-1:0] STAGE_ID   = 3'd0,
  parameter logic [CTL_ID_W-1:0]    KEY_EXT_ID = 5'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    c_s_axis_tdata,
  input  logic [TUSER_W-1:0]   c_s_axis_tuser,
  input  logic [DATA_W/8-1:0]  c_s_axis_tkeep,
  input  logic                 c_s_axis_tvalid,
  input  logic                 c_s_axis_tlast,
  output logic [DATA_W-1:0]    c_m_axis_tdata,
  output logic [TUSER_W-1:0]   c_m_axis_tuser,
  output logic [DATA_W/8-1:0]  c_m_axis_tkeep,
  output logic                 c_m_axis_tvalid,
  output logic                 c_m_axis_tlast,
  input  logic                 rd_en,
  input  logic [TBL_IDX_W-1:0] rd_idx,
  output key_entry_t           rd_entry
);

  key_entry_t           tbl [TBL_DEPTH];
  logic                 mid_pkt_reg;
  logic                 wr_en;
  logic [TBL_IDX_W-1:0] wr_idx;
  key_entry_t           wr_entry;

  // A write needs a complete one-beat packet carrying our stage and resource id
  assign wr_en = c_s_axis_tvalid & c_s_axis_tlast & ~mid_pkt_reg
               & (c_s_axis_tdata[CTL_STAGE_LSB +: CTL_STAGE_W] == STAGE_ID)
               & (c_s_axis_tdata[CTL_ID_LSB +: CTL_ID_W] == KEY_EXT_ID);
  assign wr_idx   = c_s_axis_tdata[CTL_IDX_LSB +: TBL_IDX_W];
  assign wr_entry = key_entry_t'(c_s_axis_tdata[CTL_ENTRY_LSB +: ENTRY_W]);

  // Track whether the current beat continues a multi-beat packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_pkt_reg <= 1'b0;
    end else if (c_s_axis_tvalid) begin
      mid_pkt_reg <= ~c_s_axis_tlast;
    end
  end

  // Table storage; cleared on reset so every index defaults to cond = 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_idx] <= wr_entry;
    end
  end

  // Registered read; a same-cycle write to the same index returns the old entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_entry <= '0;
    end else if (rd_en) begin
      rd_entry <= tbl[rd_idx];
    end
  end

  // One-register forwarding of every control beat to the lookup engine
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tdata  <= c_s_axis_tdata;
      c_m_axis_tuser  <= c_s_axis_tuser;
      c_m_axis_tkeep  <= c_s_axis_tkeep;
      c_m_axis_tvalid <= c_s_axis_tvalid;
      c_m_axis_tlast  <= c_s_axis_tlast;
    end
  end

endmodule

// File: rtl/key_extract_engine.sv
// Per-stage key extractor: two-stage pipeline that looks up the per-VLAN
// extraction entry, gathers the selected containers and condition bit into
// the lookup key, and passes the PHV through unmodified.
module key_extract_engine
  import key_extract_engine_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int PHV_LEN              = C48_SPAN + C32_SPAN + C16_SPAN + META_W,
  parameter int KEY_LEN              = KEY_W,
  parameter int KEY_EXT_ID           = 1,
  parameter int VLAN_OFF             = 129
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_valid_in,
  output logic                              ready_out,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_valid_out,
  output logic [KEY_LEN-1:0]                key_out,
  output logic                              key_valid_out,
  input  logic                              ready_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);

  localparam logic [CTL_STAGE_W-1:0] STAGE_BITS = STAGE_ID[CTL_STAGE_W-1:0];
  localparam logic [CTL_ID_W-1:0]    ID_BITS    = KEY_EXT_ID[CTL_ID_W-1:0];

  logic               advance;
  logic [PHV_LEN-1:0] s1_phv_reg;
  logic               s1_valid_reg;
  key_entry_t         entry;
  logic [C48_W-1:0]   c48 [NUM_CONT];
  logic [C32_W-1:0]   c32 [NUM_CONT];
  logic [C16_W-1:0]   c16 [NUM_CONT];
  logic [C16_W-1:0]   op_a_val;
  logic [C16_W-1:0]   op_b_val;
  logic               cond;
  logic [KEY_LEN-1:0] key_next;

  // The whole pipeline moves in lockstep with the downstream ready; nothing
  // is offered upstream while held in reset
  assign advance       = ready_in;
  assign ready_out     = ready_in & rst_n;
  assign key_valid_out = phv_valid_out;

  key_ext_cfg_table #(
    .DATA_W     (C_S_AXIS_DATA_WIDTH),
    .TUSER_W    (C_S_AXIS_TUSER_WIDTH),
    .STAGE_ID   (STAGE_BITS),
    .KEY_EXT_ID (ID_BITS)
  ) u_cfg (
    .clk             (clk),
    .rst_n           (rst_n),
    .c_s_axis_tdata  (c_s_axis_tdata),
    .c_s_axis_tuser  (c_s_axis_tuser),
    .c_s_axis_tkeep  (c_s_axis_tkeep),
    .c_s_axis_tvalid (c_s_axis_tvalid),
    .c_s_axis_tlast  (c_s_axis_tlast),
    .c_m_axis_tdata  (c_m_axis_tdata),
    .c_m_axis_tuser  (c_m_axis_tuser),
    .c_m_axis_tkeep  (c_m_axis_tkeep),
    .c_m_axis_tvalid (c_m_axis_tvalid),
    .c_m_axis_tlast  (c_m_axis_tlast),
    .rd_en           (advance & phv_valid_in),
    .rd_idx          (phv_in[VLAN_OFF +: TBL_IDX_W]),
    .rd_entry        (entry)
  );

  // Stage 1: capture the accepted PHV alongside the table read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_phv_reg   <= '0;
    end else if (advance) begin
      s1_valid_reg <= phv_valid_in;
      if (phv_valid_in) s1_phv_reg <= phv_in;
    end
  end

  // Split the stage-1 PHV into its container views
  for (genvar gi = 0; gi < NUM_CONT; gi++) begin : g_cont
    assign c48[gi] = s1_phv_reg[PHV_LEN-1-C48_W*gi -: C48_W];
    assign c32[gi] = s1_phv_reg[PHV_LEN-1-C48_SPAN-C32_W*gi -: C32_W];
    assign c16[gi] = s1_phv_reg[PHV_LEN-1-C48_SPAN-C32_SPAN-C16_W*gi -: C16_W];
  end

  // Operand decode, condition and key assembly
  always_comb begin
    op_a_val = entry.op_a[OPERAND_IMM_BIT]
             ? {{(C16_W-OPERAND_IMM_BIT){1'b0}}, entry.op_a[OPERAND_IMM_BIT-1:0]}
             : c16[entry.op_a[2:0]];
    op_b_val = entry.op_b[OPERAND_IMM_BIT]
             ? {{(C16_W-OPERAND_IMM_BIT){1'b0}}, entry.op_b[OPERAND_IMM_BIT-1:0]}
             : c16[entry.op_b[2:0]];
    cond     = cmp_eval(entry.cmp_op, op_a_val, op_b_val);
    key_next = {c48[entry.sel48_a], c48[entry.sel48_b],
                c32[entry.sel32_a], c32[entry.sel32_b],
                c16[entry.sel16_a], c16[entry.sel16_b],
                cond, 4'b0000};
  end

  // Stage 2: register outputs; bubbles clear valid but hold the data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phv_valid_out <= 1'b0;
      phv_out       <= '0;
      key_out       <= '0;
    end else if (advance) begin
      phv_valid_out <= s1_valid_reg;
      if (s1_valid_reg) begin
        phv_out <= s1_phv_reg;
        key_out <= key_next;
      end
    end
  end

endmodule
